dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data RAM between the CPU MEM stage and a debug/DMA port.
//  Fixed CPU priority with an anti-starvation counter that guarantees the debug
//  port one access after STARVE_MAX consecutive contested CPU grants. One access
//  in flight at a time. Sits between MEM-stage controls and the RAM instance;
//  raises cpu_stall to freeze the pipeline until the CPU access completes.
// PARAMETERS
//  ADDR_W      12  RAM address width (byte address bits taken from ALU_result)
//  DATA_W      32  RAM data width
//  STARVE_MAX  4   contested CPU grants allowed before debug port is forced in (1..15)
// PORTS
//  clk         in   1       system clock, all state updates on rising edge
//  rst         in   1       synchronous reset, active-high
//  cpu_req     in   1       CPU access request (MEM-stage Sel), held until not stalled
//  cpu_we      in   1       1 = write, 0 = read
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_din     in   DATA_W  CPU write data
//  cpu_mode    in   2       byte/half/word mode, passed to RAM unchanged
//  cpu_stall   out  1       CPU access not yet complete; pipeline must hold
//  cpu_rdata   out  DATA_W  registered read data
//  cpu_rvalid  out  1       one-cycle pulse, cpu_rdata valid
//  dbg_req     in   1       debug request, held until dbg_gnt
//  dbg_we/dbg_addr/dbg_din/dbg_mode  in  1/ADDR_W/DATA_W/2  as CPU equivalents
//  dbg_gnt     out  1       debug access issued this cycle
//  dbg_rdata   out  DATA_W  registered read data
//  dbg_rvalid  out  1       one-cycle pulse, dbg_rdata valid
//  ram_addr/ram_din/ram_mode  out  ADDR_W/DATA_W/2  muxed from granted owner
//  ram_sel/ram_we/ram_re      out  1  chip select, write enable, read enable
//  ram_dout    in   DATA_W  RAM read data, valid combinationally in issue cycle
// BEHAVIOUR
//  Reset: state=IDLE, starve_cnt=0, owner=CPU; all rvalid/gnt/ram_* = 0,
//   rdata regs = 0. cpu_stall = cpu_req (combinational) even during reset.
//  FSM IDLE: arbitrate every cycle. Winner: dbg if dbg_req & (~cpu_req |
//   starve_cnt==STARVE_MAX), else cpu if cpu_req, else none. Grant is
//   combinational; ram_* driven from winner; ram_sel=1; ram_we=we; ram_re=~we.
//   Winner write -> stay IDLE (write lands at this edge). Winner read ->
//   capture ram_dout into owner's rdata reg, latch owner, go RESP.
//  FSM RESP: one cycle; owner's rvalid=1; ram_sel=0; no grant; -> IDLE.
//  Latency: write completes in grant cycle; read data 1 cycle after grant.
//  cpu_stall = cpu_req & ~(cpu write granted this cycle | (RESP & owner==CPU)).
//   Read: stall 1 in issue cycle, 0 in RESP. Write uncontested: stall never 1.
//  dbg_gnt = 1 only in IDLE cycle that issues dbg access.
//  starve_cnt: +1 (saturate at STARVE_MAX) on CPU grant while dbg_req=1;
//   clear on dbg grant or any IDLE cycle with dbg_req=0.
//  Back-to-back: no grant in RESP; max one access per cycle, reads cost 2.
//  Requester drops req before grant: nothing issued, no side effects.
//  Reset mid-read (in RESP): rvalid suppressed, data dropped, IDLE next cycle.
//  ram_addr/din/mode = 0 when no grant (no X propagation to RAM).
// TESTING
//  1 CPU read 0x010 alone, RAM holds 0xDEADBEEF -> stall 1 cycle, next cycle
//    cpu_rvalid=1, cpu_rdata=0xDEADBEEF, stall 0.
//  2 CPU write 0x020=0x12345678 then dbg read 0x020 -> dbg_gnt same cycle,
//    dbg_rvalid next cycle with 0x12345678; cpu_stall never asserted.
//  3 cpu_req and dbg_req held high, all reads, STARVE_MAX=4 -> grant order
//    C,C,C,C,D,C,C,C,C,D...; dbg waits exactly 4 CPU accesses.
//  4 dbg_req only, 3 writes then read -> dbg_gnt 3 consecutive cycles, read
//    returns last written value; starve_cnt stays 0.
//  5 rst=1 in RESP cycle of CPU read -> cpu_rvalid=0, all ram_* 0 next cycle,
//    starve_cnt=0; after rst release, new read completes normally.
//  6 cpu byte write mode=2'b01 to 0x003 -> ram_mode=01, ram_addr=0x003, ram_we=1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data RAM arbiter: CPU MEM stage vs debug/DMA port, fixed CPU priority with
// an anti-starvation counter so the debug port cannot be locked out forever.
module dmem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic [1:0]        cpu_mode,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_din,
  input  logic [1:0]        dbg_mode,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic [1:0]        ram_mode,
  output logic              ram_sel,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic       owner_dbg;
  logic [3:0] starve_cnt;
  logic       in_idle;
  logic       grant_cpu;
  logic       grant_dbg;

  // Arbitration is purely combinational so a write lands in its request cycle.
  // Reset blocks any grant so the RAM sees no select while rst is high.
  always_comb begin
    in_idle   = (state == IDLE) && !rst;
    grant_dbg = in_idle && dbg_req && (!cpu_req || (starve_cnt == STARVE_LIM));
    grant_cpu = in_idle && cpu_req && !grant_dbg;
  end

  always_comb begin
    ram_sel  = 1'b0;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    ram_mode = 2'b00;
    if (grant_dbg) begin
      ram_sel  = 1'b1;
      ram_we   = dbg_we;
      ram_re   = !dbg_we;
      ram_addr = dbg_addr;
      ram_din  = dbg_din;
      ram_mode = dbg_mode;
    end else if (grant_cpu) begin
      ram_sel  = 1'b1;
      ram_we   = cpu_we;
      ram_re   = !cpu_we;
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
      ram_mode = cpu_mode;
    end
  end

  // The pipeline is released by a granted CPU write or by the CPU's response cycle.
  always_comb begin
    dbg_gnt    = grant_dbg;
    cpu_rvalid = !rst && (state == RESP) && !owner_dbg;
    dbg_rvalid = !rst && (state == RESP) && owner_dbg;
    cpu_stall  = cpu_req && (rst || !((grant_cpu && cpu_we) || cpu_rvalid));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_dbg  <= 1'b0;
      starve_cnt <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Count only CPU wins that actually made the debug port wait.
          if (grant_dbg || !dbg_req)
            starve_cnt <= '0;
          else if (grant_cpu && (starve_cnt != STARVE_LIM))
            starve_cnt <= starve_cnt + 4'd1;

          if (grant_dbg && !dbg_we) begin
            dbg_rdata <= ram_dout;
            owner_dbg <= 1'b1;
            state     <= RESP;
          end else if (grant_cpu && !cpu_we) begin
            cpu_rdata <= ram_dout;
            owner_dbg <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle vector table plus directed
// sequences for starvation ordering and reset during a read response.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_din;
  logic [1:0]  cpu_mode;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req, dbg_we;
  logic [11:0] dbg_addr;
  logic [31:0] dbg_din;
  logic [1:0]  dbg_mode;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [11:0] ram_addr;
  logic [31:0] ram_din;
  logic [1:0]  ram_mode;
  logic        ram_sel, ram_we, ram_re;
  logic [31:0] ram_dout;

  logic [31:0] mem [0:4095];

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_din;
    logic [1:0]  cpu_mode;
    logic        dbg_req, dbg_we;
    logic [11:0] dbg_addr;
    logic [31:0] dbg_din;
    logic        exp_stall, exp_cpu_rvalid;
    logic [31:0] exp_cpu_rdata;
    logic        exp_dbg_gnt, exp_dbg_rvalid;
    logic [31:0] exp_dbg_rdata;
    logic        exp_sel, exp_we, exp_re;
    logic [11:0] exp_addr;
    logic [31:0] exp_din;
    logic [1:0]  exp_mode;
  } vec_t;

  vec_t vecs [17];

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_mode(cpu_mode), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_din(dbg_din),
    .dbg_mode(dbg_mode), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_mode(ram_mode),
    .ram_sel(ram_sel), .ram_we(ram_we), .ram_re(ram_re), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Word-per-address RAM model; 0x010 is preloaded whenever reset is held.
  always @(posedge clk) begin
    if (rst)
      mem[16] <= 32'hDEADBEEF;
    else if (ram_sel && ram_we)
      mem[ram_addr] <= ram_din;
  end
  assign ram_dout = mem[ram_addr];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst      = v.rst;
    cpu_req  = v.cpu_req;
    cpu_we   = v.cpu_we;
    cpu_addr = v.cpu_addr;
    cpu_din  = v.cpu_din;
    cpu_mode = v.cpu_mode;
    dbg_req  = v.dbg_req;
    dbg_we   = v.dbg_we;
    dbg_addr = v.dbg_addr;
    dbg_din  = v.dbg_din;
    dbg_mode = 2'b00;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    check({t, ".cpu_stall"},  {31'd0, cpu_stall},  {31'd0, v.exp_stall});
    check({t, ".cpu_rvalid"}, {31'd0, cpu_rvalid}, {31'd0, v.exp_cpu_rvalid});
    check({t, ".cpu_rdata"},  cpu_rdata,           v.exp_cpu_rdata);
    check({t, ".dbg_gnt"},    {31'd0, dbg_gnt},    {31'd0, v.exp_dbg_gnt});
    check({t, ".dbg_rvalid"}, {31'd0, dbg_rvalid}, {31'd0, v.exp_dbg_rvalid});
    check({t, ".dbg_rdata"},  dbg_rdata,           v.exp_dbg_rdata);
    check({t, ".ram_sel"},    {31'd0, ram_sel},    {31'd0, v.exp_sel});
    check({t, ".ram_we"},     {31'd0, ram_we},     {31'd0, v.exp_we});
    check({t, ".ram_re"},     {31'd0, ram_re},     {31'd0, v.exp_re});
    check({t, ".ram_addr"},   {20'd0, ram_addr},   {20'd0, v.exp_addr});
    check({t, ".ram_din"},    ram_din,             v.exp_din);
    check({t, ".ram_mode"},   {30'd0, ram_mode},   {30'd0, v.exp_mode});
  endtask

  task automatic idle_inputs();
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0; cpu_mode = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_din = '0; dbg_mode = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int grants;
    int cycles;
    logic [31:0] exp_who;

    // rst cpu_req cpu_we cpu_addr cpu_din cpu_mode dbg_req dbg_we dbg_addr dbg_din |
    // stall crv crdata dgnt drv drdata sel we re addr din mode
    vecs[0]  = '{1,1,0,12'h010,32'h0,2'd0, 0,0,12'h000,32'h0,  1,0,32'h0,        0,0,32'h0,        0,0,0,12'h000,32'h0,2'd0};
    vecs[1]  = '{0,1,0,12'h010,32'h0,2'd0, 0,0,12'h000,32'h0,  1,0,32'h0,        0,0,32'h0,        1,0,1,12'h010,32'h0,2'd0};
    vecs[2]  = '{0,1,0,12'h010,32'h0,2'd0, 0,0,12'h000,32'h0,  0,1,32'hDEADBEEF, 0,0,32'h0,        0,0,0,12'h000,32'h0,2'd0};
    vecs[3]  = '{0,0,0,12'h000,32'h0,2'd0, 0,0,12'h000,32'h0,  0,0,32'hDEADBEEF, 0,0,32'h0,        0,0,0,12'h000,32'h0,2'd0};
    vecs[4]  = '{0,1,1,12'h020,32'h12345678,2'd2, 0,0,12'h000,32'h0, 0,0,32'hDEADBEEF, 0,0,32'h0, 1,1,0,12'h020,32'h12345678,2'd2};
    vecs[5]  = '{0,0,0,12'h000,32'h0,2'd0, 1,0,12'h020,32'h0,  0,0,32'hDEADBEEF, 1,0,32'h0,        1,0,1,12'h020,32'h0,2'd0};
    vecs[6]  = '{0,0,0,12'h000,32'h0,2'd0, 0,0,12'h000,32'h0,  0,0,32'hDEADBEEF, 0,1,32'h12345678, 0,0,0,12'h000,32'h0,2'd0};
    vecs[7]  = '{0,0,0,12'h000,32'h0,2'd0, 1,1,12'h040,32'h11, 0,0,32'hDEADBEEF, 1,0,32'h12345678, 1,1,0,12'h040,32'h11,2'd0};
    vecs[8]  = '{0,0,0,12'h000,32'h0,2'd0, 1,1,12'h040,32'h22, 0,0,32'hDEADBEEF, 1,0,32'h12345678, 1,1,0,12'h040,32'h22,2'd0};
    vecs[9]  = '{0,0,0,12'h000,32'h0,2'd0, 1,1,12'h040,32'h33, 0,0,32'hDEADBEEF, 1,0,32'h12345678, 1,1,0,12'h040,32'h33,2'd0};
    vecs[10] = '{0,0,0,12'h000,32'h0,2'd0, 1,0,12'h040,32'h0,  0,0,32'hDEADBEEF, 1,0,32'h12345678, 1,0,1,12'h040,32'h0,2'd0};
    vecs[11] = '{0,0,0,12'h000,32'h0,2'd0, 0,0,12'h000,32'h0,  0,0,32'hDEADBEEF, 0,1,32'h33,       0,0,0,12'h000,32'h0,2'd0};
    vecs[12] = '{0,1,1,12'h003,32'hAB,2'd1, 0,0,12'h000,32'h0, 0,0,32'hDEADBEEF, 0,0,32'h33,       1,1,0,12'h003,32'hAB,2'd1};
    vecs[13] = '{0,1,0,12'h010,32'h0,2'd0, 1,0,12'h020,32'h0,  1,0,32'hDEADBEEF, 0,0,32'h33,       1,0,1,12'h010,32'h0,2'd0};
    vecs[14] = '{0,1,0,12'h010,32'h0,2'd0, 1,0,12'h020,32'h0,  0,1,32'hDEADBEEF, 0,0,32'h33,       0,0,0,12'h000,32'h0,2'd0};
    vecs[15] = '{0,0,0,12'h000,32'h0,2'd0, 1,0,12'h020,32'h0,  0,0,32'hDEADBEEF, 1,0,32'h33,       1,0,1,12'h020,32'h0,2'd0};
    vecs[16] = '{0,0,0,12'h000,32'h0,2'd0, 0,0,12'h000,32'h0,  0,0,32'hDEADBEEF, 0,1,32'h12345678, 0,0,0,12'h000,32'h0,2'd0};

    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i], i);
      next_cycle();
    end

    // Both ports hammer reads: expect C,C,C,C,D repeating.
    idle_inputs();
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 12'h010;
    dbg_req = 1'b1; dbg_addr = 12'h020;
    grants = 0;
    cycles = 0;
    while (grants < 10 && cycles < 60) begin
      @(negedge clk);
      if (ram_sel) begin
        exp_who = ((grants % 5) == 4) ? 32'd1 : 32'd0;
        check($sformatf("starve_grant%0d", grants), {31'd0, dbg_gnt}, exp_who);
        grants++;
      end
      next_cycle();
      cycles++;
    end
    check("starve_grant_count", grants, 32'd10);

    // Reset lands in the response cycle of a CPU read.
    idle_inputs();
    next_cycle();
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    @(negedge clk);
    check("rstmid_issue_stall", {31'd0, cpu_stall}, 32'd1);
    check("rstmid_issue_sel", {31'd0, ram_sel}, 32'd1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check("rstmid_stall", {31'd0, cpu_stall}, 32'd1);
    check("rstmid_sel", {31'd0, ram_sel}, 32'd0);
    next_cycle();
    rst = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    check("rstpost_sel", {31'd0, ram_sel}, 32'd0);
    check("rstpost_addr", {20'd0, ram_addr}, 32'd0);
    check("rstpost_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    check("rstpost_rdata", cpu_rdata, 32'd0);
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 12'h020;
    @(negedge clk);
    check("rstnew_issue_stall", {31'd0, cpu_stall}, 32'd1);
    check("rstnew_issue_addr", {20'd0, ram_addr}, 32'h020);
    next_cycle();
    @(negedge clk);
    check("rstnew_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    check("rstnew_rdata", cpu_rdata, 32'h12345678);
    check("rstnew_stall", {31'd0, cpu_stall}, 32'd0);
    next_cycle();
    idle_inputs();
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
